riscv_str_issue: RTL and testbench

Issue/sequencing stage directly upstream of the string-operation unit (`riscv_str_ops`) in the cv32e40p string extension. It accepts string instructions (operator, 32-bit operand, destination tag) from the ID/EX side over a valid/ready handshake and buffers them in a small FIFO. It drives the string unit one instruction per cycle and captures the returned result into a single-entry output register. That register is presented to writeback over a second valid/ready handshake, so backpressure from writeback never stalls the string unit mid-operation.

---
 rtl/cv32e40p_pkg.sv | 21 ++
 rtl/riscv_str_fifo.sv | 63 ++++++
 rtl/riscv_str_issue.sv | 85 ++++++++
 tb/tb_riscv_str_issue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the cv32e40p string extension: operator codes and
// the request payload carried through the issue stage.
package cv32e40p_pkg;

   localparam int unsigned STR_OP_WIDTH = 2;

   localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd0;
   localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd1;
   localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd2;
   localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'd3;

   // Storage width of the destination tag inside the payload.
   localparam int unsigned STR_TAG_W = 5;

   typedef struct packed {
      logic [STR_OP_WIDTH-1:0] op;
      logic [31:0]             operand;
      logic [STR_TAG_W-1:0]    tag;
   } str_req_t;

endpackage

// File: rtl/riscv_str_fifo.sv
// Circular request buffer with naturally wrapping pointers, occupancy counter
// and synchronous flush. Push/pop requests are masked internally on full/empty.
module riscv_str_fifo
   import cv32e40p_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = str_req_t
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  T     wdata,
   input  logic pop,
   output T     rdata,
   output logic empty,
   output logic full
);

   localparam int unsigned AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_str_issue.sv
// Issue stage for the string unit: buffers requests, drives one operation per
// cycle into riscv_str_ops and holds its result for writeback.
module riscv_str_issue
   import cv32e40p_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [STR_OP_WIDTH-1:0] req_op_i,
   input  logic [31:0]             req_operand_i,
   input  logic [TAG_W-1:0]        req_tag_i,
   output logic                    str_en_o,
   output logic [STR_OP_WIDTH-1:0] str_op_o,
   output logic [31:0]             str_operand_o,
   input  logic [31:0]             str_result_i,
   output logic                    res_valid_o,
   input  logic                    res_ready_i,
   output logic [31:0]             res_data_o,
   output logic [TAG_W-1:0]        res_tag_o,
   output logic                    busy_o
);

   str_req_t wreq;
   str_req_t head;
   logic     fifo_empty;
   logic     fifo_full;
   logic     push;
   logic     issue;

   assign wreq = '{op: req_op_i, operand: req_operand_i, tag: STR_TAG_W'(req_tag_i)};

   // Ready depends on registered occupancy only; it is held low during reset.
   assign req_ready_o = !rst && !fifo_full;
   assign push        = req_valid_i && req_ready_o && !flush_i;
   assign issue       = !fifo_empty && (!res_valid_o || res_ready_i) && !flush_i;

   riscv_str_fifo #(
      .DEPTH (DEPTH),
      .T     (str_req_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_i),
      .push  (push),
      .wdata (wreq),
      .pop   (issue),
      .rdata (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_comb begin
      str_en_o      = issue;
      str_op_o      = '0;
      str_operand_o = '0;
      if (issue) begin
         str_op_o      = head.op;
         str_operand_o = head.operand;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_o <= 1'b0;
         res_data_o  <= '0;
         res_tag_o   <= '0;
      end else if (flush_i) begin
         res_valid_o <= 1'b0;
      end else if (issue) begin
         res_valid_o <= 1'b1;
         res_data_o  <= str_result_i;
         res_tag_o   <= TAG_W'(head.tag);
      end else if (res_ready_i) begin
         res_valid_o <= 1'b0;
      end
   end

   assign busy_o = !fifo_empty || res_valid_o;

endmodule

// File: tb/tb_riscv_str_issue.sv
// Bench for riscv_str_issue: a byte-wise string unit model drives str_result_i,
// and a queue-based model of the stage predicts every output each cycle.
module tb_riscv_str_issue;
   import cv32e40p_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_operand;
   logic [4:0]  req_tag;
   logic        str_en;
   logic [1:0]  str_op;
   logic [31:0] str_operand;
   logic [31:0] str_result;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [4:0]  res_tag;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_str_issue #(
      .DEPTH (DEPTH),
      .TAG_W (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_op_i      (req_op),
      .req_operand_i (req_operand),
      .req_tag_i     (req_tag),
      .str_en_o      (str_en),
      .str_op_o      (str_op),
      .str_operand_o (str_operand),
      .str_result_i  (str_result),
      .res_valid_o   (res_valid),
      .res_ready_i   (res_ready),
      .res_data_o    (res_data),
      .res_tag_o     (res_tag),
      .busy_o        (busy)
   );

   // Behavioural string unit: per-byte case change, leetspeak, rot13.
   function automatic logic [31:0] str_model(logic [1:0] op, logic [31:0] x);
      logic [31:0] r;
      logic [7:0]  c;
      for (int b = 0; b < 4; b++) begin
         c = x[8*b +: 8];
         case (op)
            STR_OP_UPPER: if (c >= "a" && c <= "z") c = c - 8'd32;
            STR_OP_LOWER: if (c >= "A" && c <= "Z") c = c + 8'd32;
            STR_OP_LEET: begin
               if (c == "a") c = "4";
               else if (c == "e") c = "3";
               else if (c == "i") c = "1";
               else if (c == "o") c = "0";
            end
            default: begin
               if (c >= "a" && c <= "z") c = 8'("a" + (c - "a" + 13) % 26);
               else if (c >= "A" && c <= "Z") c = 8'("A" + (c - "A" + 13) % 26);
            end
         endcase
         r[8*b +: 8] = c;
      end
      return r;
   endfunction

   assign str_result = str_model(str_op, str_operand);

   typedef struct {
      logic [1:0]  op;
      logic [31:0] operand;
      logic [4:0]  tag;
   } req_t;

   req_t        mq[$];
   logic        slot_v;
   logic [31:0] slot_d;
   logic [4:0]  slot_t;
   int          retired;
   logic [4:0]  last_tag;
   int          en_pulses;
   logic        s_en, s_rr, s_rv;
   logic [4:0]  s_tag;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      slot_v = 1'b0;
      slot_d = '0;
      slot_t = '0;
   endtask

   // Called at posedge+1; applies inputs, checks at negedge, advances the model.
   task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] opd,
                        input logic [4:0] tag, input logic rdy, input logic fl);
      logic exp_issue;
      req_t r;
      req_valid   = v;
      req_op      = op;
      req_operand = opd;
      req_tag     = tag;
      res_ready   = rdy;
      flush       = fl;
      @(negedge clk);
      s_en  = str_en;
      s_rr  = req_ready;
      s_rv  = res_valid;
      s_tag = res_tag;
      if (str_en) en_pulses++;
      exp_issue = (mq.size() != 0) && (!slot_v || rdy) && !fl;
      chk("str_en", 32'(str_en), 32'(exp_issue));
      chk("req_ready", 32'(req_ready), 32'(mq.size() != DEPTH));
      chk("res_valid", 32'(res_valid), 32'(slot_v));
      chk("busy", 32'(busy), 32'((mq.size() != 0) || slot_v));
      if (exp_issue) begin
         chk("str_op", 32'(str_op), 32'(mq[0].op));
         chk("str_operand", str_operand, mq[0].operand);
      end else begin
         chk("str_op_idle", 32'(str_op), 32'd0);
         chk("str_operand_idle", str_operand, 32'd0);
      end
      if (slot_v) begin
         chk("res_data", res_data, slot_d);
         chk("res_tag", 32'(res_tag), 32'(slot_t));
      end
      if (fl) begin
         model_clear();
      end else begin
         if (slot_v && rdy) begin
            retired++;
            last_tag = slot_t;
         end
         if (v && mq.size() != DEPTH) begin
            r.op = op; r.operand = opd; r.tag = tag;
            mq.push_back(r);
         end
         if (exp_issue) begin
            r = mq.pop_front();
            slot_v = 1'b1;
            slot_d = str_model(r.op, r.operand);
            slot_t = r.tag;
         end else if (rdy) begin
            slot_v = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0, 5'd0, rdy, 1'b0);
   endtask

   typedef struct {
      logic       v;
      logic [4:0] tag;
      logic       rdy;
      logic       e_en;
      logic       e_rr;
      logic       e_rv;
      logic [4:0] e_tag;
   } vec_t;

   vec_t vecs[9];

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
      req_operand = '0; req_tag = '0; res_ready = 1'b0;
      model_clear();
      retired = 0; last_tag = '0; en_pulses = 0;

      // Reset state while rst is asserted.
      #3;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_str_en", 32'(str_en), 32'd0);
      #9 rst = 1'b0;
      #1 chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;

      // Single op: UPPER "abcd" with tag 3.
      en_pulses = 0;
      cycle(1'b1, STR_OP_UPPER, 32'h64636261, 5'd3, 1'b1, 1'b0);
      cycle(1'b0, 2'd0, 32'd0, 5'd0, 1'b1, 1'b0);
      chk("single_en_cycle", 32'(s_en), 32'd1);
      chk("single_rv_early", 32'(s_rv), 32'd0);
      cycle(1'b0, 2'd0, 32'd0, 5'd0, 1'b1, 1'b0);
      chk("single_rv", 32'(s_rv), 32'd1);
      chk("single_data", res_data, 32'h44434241);
      chk("single_tag", 32'(s_tag), 32'd3);
      idle(1'b1, 2);
      chk("single_en_pulses", 32'(en_pulses), 32'd1);

      // Streaming: 8 back-to-back pushes, ready never drops.
      retired = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 2'(i), 32'h6f696561 + 32'(i), 5'(i), 1'b1, 1'b0);
         chk("stream_ready", 32'(s_rr), 32'd1);
      end
      idle(1'b1, 3);
      chk("stream_count", 32'(retired), 32'd8);
      chk("stream_last_tag", 32'(last_tag), 32'd7);

      // Backpressure, table-driven.
      vecs[0] = '{1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
      vecs[1] = '{1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
      vecs[2] = '{1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
      vecs[3] = '{1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1};
      vecs[4] = '{1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1};
      vecs[5] = '{1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2};
      vecs[6] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3};
      vecs[7] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4};
      vecs[8] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
      for (int i = 0; i < 9; i++) begin
         cycle(vecs[i].v, STR_OP_LOWER, 32'h41424340 + 32'(vecs[i].tag), vecs[i].tag,
               vecs[i].rdy, 1'b0);
         chk($sformatf("bp%0d_en", i), 32'(s_en), 32'(vecs[i].e_en));
         chk($sformatf("bp%0d_rr", i), 32'(s_rr), 32'(vecs[i].e_rr));
         chk($sformatf("bp%0d_rv", i), 32'(s_rv), 32'(vecs[i].e_rv));
         if (vecs[i].e_rv) chk($sformatf("bp%0d_tag", i), 32'(s_tag), 32'(vecs[i].e_tag));
      end

      // Simultaneous push/pop at count 1 across pointer wraps.
      for (int i = 0; i < 11; i++) cycle(1'b1, STR_OP_ROT13, 32'h4e6d5a61 ^ 32'(i), 5'(i + 10),
                                         1'b1, 1'b0);
      idle(1'b1, 3);

      // Flush with FIFO full and a valid result; the push in the flush cycle is dropped.
      for (int i = 0; i < 4; i++) cycle(1'b1, STR_OP_LEET, 32'h6f696561, 5'(20 + i), 1'b0, 1'b0);
      cycle(1'b1, STR_OP_LEET, 32'h61616161, 5'd7, 1'b0, 1'b1);
      cycle(1'b0, 2'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_rv", 32'(s_rv), 32'd0);
      chk("flush_en", 32'(s_en), 32'd0);
      retired = 0;
      cycle(1'b1, STR_OP_UPPER, 32'h74737271, 5'd9, 1'b1, 1'b0);
      idle(1'b1, 4);
      chk("flush_after_count", 32'(retired), 32'd1);
      chk("flush_after_tag", 32'(last_tag), 32'd9);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 3; i++) cycle(1'b1, STR_OP_LOWER, 32'h5a595857, 5'(i + 1), 1'b0, 1'b0);
      req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_str_en", 32'(str_en), 32'd0);
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_res_data", res_data, 32'd0);
      chk("arst_res_tag", 32'(res_tag), 32'd0);
      model_clear();
      #3 rst = 1'b0;
      #1 chk("arst_release_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      idle(1'b1, 3);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 4) != 0, 2'($urandom), $urandom, 5'($urandom),
               ($urandom % 3) != 0, ($urandom % 50) == 0);
      end
      idle(1'b1, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
